// File: rtl/dec_arb_pipe.sv
// dec_arb_pipe: arbitrates among NCH code channels (fixed select or
// round-robin), decodes the granted channel's code to one-hot, and holds the
// result in a single-entry output register with a valid/ready handshake.
//
// Ports
//   clk        in  1           rising-edge clock
//   rst        in  1           synchronous active-high reset
//   code       in  NCH*SEL_W   packed channel codes, channel k at [k*SEL_W +: SEL_W]
//   en         in  NCH         per-channel request
//   mode       in  1           0 = fixed select by sel, 1 = round-robin
//   sel        in  CH_W        channel selected in mode 0
//   out_ready  in  1           downstream accepts the held entry
//   grant      out NCH         combinational one-hot grant for this cycle
//   result     out OW          registered one-hot decode of captured code
//   out_ch     out CH_W        registered index of the producing channel
//   out_valid  out 1           result/out_ch hold an unaccepted entry
module dec_arb_pipe #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned SEL_W = 2,
  localparam int unsigned OW   = 1 << SEL_W,
  localparam int unsigned CH_W = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*SEL_W-1:0] code,
  input  logic [NCH-1:0]       en,
  input  logic                 mode,
  input  logic [CH_W-1:0]      sel,
  input  logic                 out_ready,
  output logic [NCH-1:0]       grant,
  output logic [OW-1:0]        result,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_valid
);

  logic [CH_W-1:0]  ptr;
  logic             load_ok;
  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  logic [SEL_W-1:0] gnt_code;
  int unsigned      idx;

  // Output register can take a new entry when empty or being drained.
  assign load_ok = !out_valid || out_ready;

  // Grant selection; a sel outside 0..NCH-1 never matches any channel.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_code = '0;
    idx      = 0;
    if (!rst && load_ok) begin
      if (!mode) begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (CH_W'(k) == sel && en[k]) begin
            grant[k] = 1'b1;
            gnt_any  = 1'b1;
            gnt_idx  = CH_W'(k);
            gnt_code = code[k*SEL_W +: SEL_W];
          end
        end
      end else begin
        // Search ptr, ptr+1, ... wrapping; first requester wins.
        for (int unsigned i = 0; i < NCH; i++) begin
          idx = (32'(ptr) + i) % NCH;
          if (!gnt_any && en[idx]) begin
            grant[idx] = 1'b1;
            gnt_any    = 1'b1;
            gnt_idx    = CH_W'(idx);
            gnt_code   = code[idx*SEL_W +: SEL_W];
          end
        end
      end
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_ok) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        result    <= OW'(1) << gnt_code;
        out_ch    <= gnt_idx;
        if (mode) begin
          ptr <= CH_W'((32'(gnt_idx) + 1) % NCH);
        end
      end else begin
        out_valid <= 1'b0;
        result    <= '0;
      end
    end
  end

endmodule

// File: doc/dec_arb_pipe.md
DEC_ARB_PIPE -- requirements
Module: dec_arb_pipe

Interface
REQ-001 Parameter NCH, default 2: number of input code channels, legal range 2..16.
REQ-002 Parameter SEL_W, default 2: code width per channel; decoded output width is OW = 2**SEL_W; legal range 1..5.
REQ-003 Derived CH_W = max(1, clog2(NCH)).
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port code  in  NCH*SEL_W: packed channel codes; channel k occupies bits [k*SEL_W +: SEL_W].
REQ-007 Port en  in  NCH: per-channel request; en[k]=1 means code k is valid and requesting.
REQ-008 Port mode  in  1: 0 = fixed select by sel; 1 = round-robin among requesters.
REQ-009 Port sel  in  CH_W: channel selected when mode=0.
REQ-010 Port out_ready  in  1: downstream accepts result when high.
REQ-011 Port grant  out  NCH: one-hot, combinational, the channel whose code is captured this cycle; all-zero if none.
REQ-012 Port result  out  OW: registered one-hot decode of captured code.
REQ-013 Port out_ch  out  CH_W: registered index of channel that produced result.
REQ-014 Port out_valid  out  1: result/out_ch hold a valid, not-yet-accepted entry.

Function
REQ-015 Output stage is a single-entry register; load_ok = !out_valid || out_ready.
REQ-016 Mode 0: grant[sel]=1 iff load_ok && en[sel] && sel<NCH; sel>=NCH yields no grant.
REQ-017 Mode 1: search order ptr, ptr+1, ... wrapping modulo NCH; first k with en[k]=1 is granted if load_ok.
REQ-018 At most one grant bit is high per cycle; no grant when load_ok=0, regardless of en.
REQ-019 On grant to k: next cycle result = 1 << code[k], out_ch = k, out_valid = 1 (latency 1 cycle).
REQ-020 Code decode: code value v sets result bit v only; all other bits 0.
REQ-021 out_valid && !out_ready: result, out_ch, out_valid held unchanged (stall); upstream en changes do not alter held entry.
REQ-022 out_valid && out_ready && no grant: out_valid clears next cycle; result clears to 0.
REQ-023 out_valid && out_ready && grant: new entry loads same cycle (back-to-back, 1 result/cycle sustained).
REQ-024 Round-robin pointer ptr (CH_W bits) updates only on a mode-1 grant: ptr <= (k+1) mod NCH.
REQ-025 ptr is held in mode 0 and when no grant occurs; mode change takes effect on the next evaluated cycle with ptr unchanged.
REQ-026 No request (en=0 in the relevant scope): no grant, output stage behaves per REQ-021/022.
REQ-027 Producer handshake: a channel's code is consumed only in a cycle with its grant bit high; producer holds en/code until granted.

Reset
REQ-028 While rst=1 at a clk edge: out_valid=0, result=0, out_ch=0, ptr=0.
REQ-029 Reset mid-operation discards any held entry; grant is forced all-zero while rst=1.
REQ-030 First grant possible in the first cycle with rst=0.

Verification (NCH=2, SEL_W=2)
REQ-031 Fixed select: mode=0, sel=1, en=2'b11, code={2'b10,2'b01}, out_ready=1 -> grant=2'b10; next cycle result=4'b0100, out_ch=1, out_valid=1.
REQ-032 Round-robin fairness: mode=1, en=2'b11 held, out_ready=1 from reset -> grants alternate 01,10,01,10; out_ch alternates 0,1,0,1.
REQ-033 Stall: entry result=4'b0001 valid, out_ready=0 for 3 cycles with en=2'b11 -> grant=0, result held 4'b0001; out_ready=1 -> new entry loads same cycle.
REQ-034 Drain: out_valid=1, out_ready=1, en=0 -> next cycle out_valid=0, result=4'b0000.
REQ-035 Reset mid-stream: out_valid=1, ptr=1, assert rst one cycle -> out_valid=0, result=0, out_ch=0; next mode-1 grant with en=2'b11 goes to channel 0.
REQ-036 Invalid select: NCH=3 build, mode=0, sel=3, en=3'b111 -> grant=0, out_valid stays 0.
